key_event_detect: RTL and testbench

Parametrised keypad press detector for the keypad scanning path. It sits between the row/column scanner and the display/decoder logic. It debounces a press on a ROWS x COLS matrix and emits exactly one `key_valid` pulse per debounced press, carrying the row/column index. Release is debounced as well, and an optional auto-repeat mode re-emits the key while it is held.

---
 rtl/key_event_detect.sv | 187 ++++++++++++++++++
 tb/tb_key_event_detect.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_event_detect
// Description : Debounced keypad press/release detector with optional
//               auto-repeat, reporting the captured row/column index.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_detect #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int DEBOUNCE      = 16,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int c_CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] rows,
    input  logic [COLS-1:0] cols,
    output logic            key_valid,
    output logic [c_RW-1:0] key_row,
    output logic [c_CW-1:0] key_col,
    output logic            key_held,
    output logic            key_repeat
);

    localparam int c_DBW    = $clog2(DEBOUNCE + 1);
    localparam int c_RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPW    = $clog2(c_RP_MAX + 1);

    localparam logic [c_DBW-1:0] c_DB_MAX   = c_DBW'(DEBOUNCE);
    localparam logic [c_DBW-1:0] c_DB_ONE   = c_DBW'(1);
    localparam logic [c_RPW-1:0] c_RP_SAT   = c_RPW'(c_RP_MAX);
    localparam logic [c_RPW-1:0] c_RP_FIRST = c_RPW'(REPEAT_DELAY);
    localparam logic [c_RPW-1:0] c_RP_NEXT  = c_RPW'(REPEAT_PERIOD);
    localparam logic             c_REP_ON   = (REPEAT_EN != 0);
    localparam logic             c_DB_SINGLE = (DEBOUNCE == 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_DBW-1:0]  r_db;
    logic [c_RPW-1:0]  r_rp;
    logic              r_rep_seen;
    logic [c_RW-1:0]   r_row;
    logic [c_CW-1:0]   r_col;
    logic              r_valid;
    logic              r_repeat;
    logic              r_held;

    logic [c_RW-1:0]   w_row_idx;
    logic [c_CW-1:0]   w_col_idx;
    logic              w_qual;
    logic              w_hit;
    logic              w_miss;
    logic [c_DBW-1:0]  w_db_inc;
    logic              w_db_done;
    logic [c_RPW-1:0]  w_rp_inc;
    logic [c_RPW-1:0]  w_rp_target;
    logic              w_rp_fire;

    // Lowest set bit wins, so scan from the top down.
    always_comb begin
        w_row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (rows[i]) w_row_idx = c_RW'(i);
        end
        w_col_idx = '0;
        for (int j = COLS - 1; j >= 0; j--) begin
            if (cols[j]) w_col_idx = c_CW'(j);
        end
    end

    assign w_qual      = cols[r_col];
    assign w_hit       = w_qual &  rows[r_row];
    assign w_miss      = w_qual & ~rows[r_row];
    assign w_db_inc    = (r_db == c_DB_MAX) ? r_db : r_db + c_DB_ONE;
    assign w_db_done   = (w_db_inc == c_DB_MAX);
    assign w_rp_inc    = (r_rp == c_RP_SAT) ? r_rp : r_rp + c_RPW'(1);
    assign w_rp_target = r_rep_seen ? c_RP_NEXT : c_RP_FIRST;
    // Repeat counter restarts at each pulse, so target switches delay -> period.
    assign w_rp_fire   = c_REP_ON && (w_rp_inc == w_rp_target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_db       <= '0;
            r_rp       <= '0;
            r_rep_seen <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_valid    <= 1'b0;
            r_repeat   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_repeat <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|rows) begin
                        r_row <= w_row_idx;
                        r_col <= w_col_idx;
                        r_db  <= c_DB_ONE;
                        if (c_DB_SINGLE) begin
                            r_state    <= S_HELD;
                            r_valid    <= 1'b1;
                            r_held     <= 1'b1;
                            r_rp       <= '0;
                            r_rep_seen <= 1'b0;
                        end else begin
                            r_state <= S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (w_hit) begin
                        r_db <= w_db_inc;
                        if (w_db_done) begin
                            r_state    <= S_HELD;
                            r_valid    <= 1'b1;
                            r_held     <= 1'b1;
                            r_rp       <= '0;
                            r_rep_seen <= 1'b0;
                        end
                    end else if (w_miss) begin
                        r_state <= S_IDLE;
                        r_db    <= '0;
                    end
                end
                S_HELD: begin
                    if (w_miss) begin
                        if (c_DB_SINGLE) begin
                            r_state <= S_IDLE;
                            r_held  <= 1'b0;
                            r_db    <= '0;
                        end else begin
                            r_state <= S_RELEASE;
                            r_db    <= c_DB_ONE;
                        end
                    end else if (w_rp_fire) begin
                        r_valid    <= 1'b1;
                        r_repeat   <= 1'b1;
                        r_rp       <= '0;
                        r_rep_seen <= 1'b1;
                    end else begin
                        r_rp <= w_rp_inc;
                    end
                end
                S_RELEASE: begin
                    if (w_miss) begin
                        r_db <= w_db_inc;
                        if (w_db_done) begin
                            r_state <= S_IDLE;
                            r_held  <= 1'b0;
                            r_db    <= '0;
                        end
                    end else if (w_hit) begin
                        r_state    <= S_HELD;
                        r_rp       <= '0;
                        r_rep_seen <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_held  <= 1'b0;
                    r_db    <= '0;
                end
            endcase
        end
    end

    assign key_valid  = r_valid;
    assign key_repeat = r_repeat;
    assign key_held   = r_held;
    assign key_row    = r_row;
    assign key_col    = r_col;

endmodule
`default_nettype wire

// File: tb/tb_key_event_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_key_event_detect
// Description : Scoreboard bench; two instances (auto-repeat off / on).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_detect;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        rep;
    } exp_t;

    logic        clk = 1'b0;
    logic        r_reset;
    logic [3:0]  r_rows;
    logic [3:0]  r_cols;
    logic [31:0] r_cyc = 32'd0;

    logic       w_valid0, w_rep0, w_held0;
    logic [1:0] w_row0, w_col0;
    logic       w_valid1, w_rep1, w_held1;
    logic [1:0] w_row1, w_col1;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t q0[$];
    exp_t q1[$];

    key_event_detect #(
        .ROWS(4), .COLS(4), .DEBOUNCE(4), .REPEAT_EN(0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) u_dut0 (
        .clk(clk), .reset(r_reset), .rows(r_rows), .cols(r_cols),
        .key_valid(w_valid0), .key_row(w_row0), .key_col(w_col0),
        .key_held(w_held0), .key_repeat(w_rep0)
    );

    key_event_detect #(
        .ROWS(4), .COLS(4), .DEBOUNCE(4), .REPEAT_EN(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) u_dut1 (
        .clk(clk), .reset(r_reset), .rows(r_rows), .cols(r_cols),
        .key_valid(w_valid1), .key_row(w_row1), .key_col(w_col1),
        .key_held(w_held1), .key_repeat(w_rep1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) r_cyc <= r_cyc + 32'd1;

    // Pulses are matched in order against what each task predicted.
    always @(negedge clk) begin
        exp_t e;
        if (w_valid0 === 1'b1) begin
            n_total++;
            if (q0.size() == 0) begin
                $display("FAIL dut0_pulse: unexpected key_valid at cycle %0d row %0d col %0d rep %0b, required none",
                         r_cyc, w_row0, w_col0, w_rep0);
            end else begin
                e = q0.pop_front();
                if ({r_cyc, w_row0, w_col0, w_rep0} !== e)
                    $display("FAIL dut0_pulse: got cycle %0d row %0d col %0d rep %0b, required cycle %0d row %0d col %0d rep %0b",
                             r_cyc, w_row0, w_col0, w_rep0, e.cyc, e.row, e.col, e.rep);
                else
                    n_pass++;
            end
        end
        if (w_valid1 === 1'b1) begin
            n_total++;
            if (q1.size() == 0) begin
                $display("FAIL dut1_pulse: unexpected key_valid at cycle %0d row %0d col %0d rep %0b, required none",
                         r_cyc, w_row1, w_col1, w_rep1);
            end else begin
                e = q1.pop_front();
                if ({r_cyc, w_row1, w_col1, w_rep1} !== e)
                    $display("FAIL dut1_pulse: got cycle %0d row %0d col %0d rep %0b, required cycle %0d row %0d col %0d rep %0b",
                             r_cyc, w_row1, w_col1, w_rep1, e.cyc, e.row, e.col, e.rep);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input int which, input logic [31:0] c,
                                     input logic [1:0] r, input logic [1:0] k, input logic rep);
        exp_t e;
        e.cyc = c; e.row = r; e.col = k; e.rep = rep;
        if (which != 1) q0.push_back(e);
        if (which != 0) q1.push_back(e);
    endfunction

    task automatic test_reset();
        r_reset = 1'b0; r_rows = 4'h0; r_cols = 4'h0;
        #1 r_reset = 1'b1;
        tick(2);
        n_total++; if (w_valid0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", w_valid0); else n_pass++;
        n_total++; if (w_rep0 !== 1'b0) $display("FAIL reset_repeat: got %b want 0", w_rep0); else n_pass++;
        n_total++; if (w_held0 !== 1'b0) $display("FAIL reset_held: got %b want 0", w_held0); else n_pass++;
        n_total++; if (w_row0 !== 2'd0) $display("FAIL reset_row: got %0d want 0", w_row0); else n_pass++;
        n_total++; if (w_col0 !== 2'd0) $display("FAIL reset_col: got %0d want 0", w_col0); else n_pass++;
        n_total++;
        if ({w_valid1, w_rep1, w_held1, w_row1, w_col1} !== 7'd0)
            $display("FAIL reset_dut1: got %b want 0000000", {w_valid1, w_rep1, w_held1, w_row1, w_col1});
        else n_pass++;
        r_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_clean_press();
        logic [31:0] n;
        r_cols = 4'b0100; r_rows = 4'b0001;
        n = r_cyc;
        push_exp(2, n + 4, 2'd0, 2'd2, 1'b0);
        tick(20);
        n_total++; if (w_held0 !== 1'b1) $display("FAIL clean_held: got %b want 1", w_held0); else n_pass++;
        n_total++; if (w_row0 !== 2'd0) $display("FAIL clean_row: got %0d want 0", w_row0); else n_pass++;
        n_total++; if (w_col0 !== 2'd2) $display("FAIL clean_col: got %0d want 2", w_col0); else n_pass++;
        r_rows = 4'b0000;
        tick(6);
        n_total++; if ({w_held0, w_held1} !== 2'b00) $display("FAIL clean_release: got %b want 00", {w_held0, w_held1}); else n_pass++;
        n_total++; if (q0.size() + q1.size() !== 0) $display("FAIL clean_missing: got %0d pending want 0", q0.size() + q1.size()); else n_pass++;
    endtask

    task automatic test_bounce();
        logic [31:0] n;
        r_cols = 4'b0100; r_rows = 4'b0010;
        tick(2);
        r_rows = 4'b0000;
        tick(3);
        n_total++; if ({w_held0, w_held1} !== 2'b00) $display("FAIL bounce_held: got %b want 00", {w_held0, w_held1}); else n_pass++;
        r_rows = 4'b0010;
        n = r_cyc;
        push_exp(2, n + 4, 2'd1, 2'd2, 1'b0);
        tick(10);
        n_total++; if ({w_held0, w_row0} !== 3'b101) $display("FAIL bounce_repress: got held/row %b want 101", {w_held0, w_row0}); else n_pass++;
        r_rows = 4'b0000;
        tick(6);
        n_total++; if (q0.size() + q1.size() !== 0) $display("FAIL bounce_missing: got %0d pending want 0", q0.size() + q1.size()); else n_pass++;
    endtask

    task automatic test_release_debounce();
        logic [31:0] n;
        logic [6:0]  pat;
        logic [6:0]  held_exp;
        pat      = 7'b0000100;
        held_exp = 7'b0111111;
        r_cols = 4'b0001; r_rows = 4'b1000;
        n = r_cyc;
        push_exp(2, n + 4, 2'd3, 2'd0, 1'b0);
        tick(8);
        for (int i = 0; i < 7; i++) begin
            r_rows = pat[i] ? 4'b1000 : 4'b0000;
            tick(1);
            n_total++;
            if ({w_held0, w_held1} !== {2{held_exp[i]}})
                $display("FAIL release_held_%0d: got %b want %b", i, {w_held0, w_held1}, {2{held_exp[i]}});
            else n_pass++;
        end
        tick(4);
        n_total++; if (q0.size() + q1.size() !== 0) $display("FAIL release_missing: got %0d pending want 0", q0.size() + q1.size()); else n_pass++;
    endtask

    task automatic test_auto_repeat();
        logic [31:0] p;
        r_cols = 4'b0001; r_rows = 4'b0001;
        p = r_cyc + 4;
        push_exp(2, p, 2'd0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(1, p + 20 + 8 * k, 2'd0, 2'd0, 1'b1);
        tick(54);
        r_rows = 4'b0000;
        tick(8);
        n_total++; if ({w_held0, w_held1} !== 2'b00) $display("FAIL repeat_release: got %b want 00", {w_held0, w_held1}); else n_pass++;
        n_total++; if (q0.size() + q1.size() !== 0) $display("FAIL repeat_missing: got %0d pending want 0", q0.size() + q1.size()); else n_pass++;
    endtask

    task automatic test_column_gating();
        logic [31:0] n;
        r_rows = 4'b0110; r_cols = 4'b1000;
        n = r_cyc;
        push_exp(2, n + 6, 2'd1, 2'd3, 1'b0);
        tick(1); r_cols = 4'b0001;
        tick(1); r_cols = 4'b1000;
        tick(1); r_cols = 4'b0001;
        tick(1); r_cols = 4'b1000;
        tick(8);
        n_total++; if (w_row1 !== 2'd1) $display("FAIL gating_row: got %0d want 1", w_row1); else n_pass++;
        n_total++; if (w_col1 !== 2'd3) $display("FAIL gating_col: got %0d want 3", w_col1); else n_pass++;
        n_total++; if (w_held0 !== 1'b1) $display("FAIL gating_held: got %b want 1", w_held0); else n_pass++;
        r_rows = 4'b0000;
        tick(8);
        n_total++; if (q0.size() + q1.size() !== 0) $display("FAIL gating_missing: got %0d pending want 0", q0.size() + q1.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_held();
        logic [31:0] n;
        r_rows = 4'b0100; r_cols = 4'b0010;
        n = r_cyc;
        push_exp(2, n + 4, 2'd2, 2'd1, 1'b0);
        tick(8);
        n_total++; if ({w_held0, w_held1} !== 2'b11) $display("FAIL midreset_pre: got %b want 11", {w_held0, w_held1}); else n_pass++;
        #2 r_reset = 1'b1;
        #1;
        n_total++;
        if ({w_valid0, w_rep0, w_held0, w_row0, w_col0} !== 7'd0)
            $display("FAIL midreset_dut0: got %b want 0000000", {w_valid0, w_rep0, w_held0, w_row0, w_col0});
        else n_pass++;
        n_total++;
        if ({w_valid1, w_rep1, w_held1, w_row1, w_col1} !== 7'd0)
            $display("FAIL midreset_dut1: got %b want 0000000", {w_valid1, w_rep1, w_held1, w_row1, w_col1});
        else n_pass++;
        tick(1);
        r_reset = 1'b0;
        n = r_cyc;
        push_exp(2, n + 4, 2'd2, 2'd1, 1'b0);
        tick(8);
        n_total++; if ({w_held0, w_held1} !== 2'b11) $display("FAIL midreset_repress: got %b want 11", {w_held0, w_held1}); else n_pass++;
        r_rows = 4'b0000;
        tick(8);
        n_total++; if ({w_held0, w_held1} !== 2'b00) $display("FAIL midreset_release: got %b want 00", {w_held0, w_held1}); else n_pass++;
        n_total++; if (q0.size() + q1.size() !== 0) $display("FAIL midreset_missing: got %0d pending want 0", q0.size() + q1.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_debounce();
        test_auto_repeat();
        test_column_gating();
        test_reset_mid_held();
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
